pc_redirect_ctrl: RTL

- Stage-2 control-flow resolver and the consumer end of the fetch PC interface.
- Registers the stage-1 PC and valid bit into stage 2, then decides per cycle whether the next fetch is sequential (PC+4) or redirected.
- Drives the PC select, redirect target and stall lines back to the stage-1 program counter.
- Holds a pending redirect across instruction-cache stalls and kills the wrong-path instruction in stage 1.

---
 rtl/pc_redirect_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/pc_redirect_ctrl.sv
// Stage-2 control-flow resolver: registers the stage-1 PC, picks sequential vs redirected fetch,
// and holds a pending redirect across icache stalls. Optional counters under PC_REDIRECT_PERF_EN.
`ifndef PC_RESET
`define PC_RESET 32'h0000_0000
`endif

module pc_redirect_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_s1,
  input  logic            icache_stall,
  input  logic            is_jal,
  input  logic            is_jalr,
  input  logic            is_branch,
  input  logic            br_taken,
  input  logic [XLEN-1:0] alu_out,
  output logic            pc_sel,
  output logic [XLEN-1:0] target_out,
  output logic            stall_out,
  output logic            flush_s1,
  output logic [XLEN-1:0] pc_s2,
  output logic            s2_valid,
  output logic            misalign
`ifdef PC_REDIRECT_PERF_EN
  ,
  output logic [31:0]     redirect_cnt,
  output logic [31:0]     kill_cnt
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pend_target_q, pend_target_d;
  logic [XLEN-1:0] pc_s2_q, pc_s2_d;
  logic            s2_valid_q, s2_valid_d;
  logic            redirect_req;
  logic [XLEN-1:0] eff_target;

  always_comb begin
    redirect_req = s2_valid_q & (is_jal | is_jalr | (is_branch & br_taken));
    eff_target   = is_jalr ? {alu_out[XLEN-1:1], 1'b0} : alu_out;
  end

  // In HOLD the stage-2 instruction is frozen, so its redirect_req is the one already latched.
  always_comb begin
    state_d       = state_q;
    pend_target_d = pend_target_q;
    pc_sel        = 1'b0;
    target_out    = eff_target;
    flush_s1      = 1'b0;
    misalign      = 1'b0;
    case (state_q)
      IDLE: begin
        if (redirect_req) begin
          pc_sel   = 1'b1;
          flush_s1 = 1'b1;
          misalign = eff_target[1];
          if (icache_stall) begin
            pend_target_d = eff_target;
            state_d       = HOLD;
          end
        end
      end
      HOLD: begin
        pc_sel     = 1'b1;
        flush_s1   = 1'b1;
        target_out = pend_target_q;
        if (!icache_stall) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (reset) begin
      pc_sel        = 1'b0;
      flush_s1      = 1'b0;
      misalign      = 1'b0;
      state_d       = IDLE;
      pend_target_d = '0;
    end
  end

  always_comb begin
    pc_s2_d    = pc_s2_q;
    s2_valid_d = s2_valid_q;
    if (reset) begin
      pc_s2_d    = XLEN'(`PC_RESET);
      s2_valid_d = 1'b0;
    end else if (!icache_stall) begin
      pc_s2_d    = pc_s1;
      s2_valid_d = !flush_s1;
    end
  end

  always_ff @(posedge clk) begin
    state_q       <= state_d;
    pend_target_q <= pend_target_d;
    pc_s2_q       <= pc_s2_d;
    s2_valid_q    <= s2_valid_d;
  end

  assign stall_out = icache_stall;
  assign pc_s2     = pc_s2_q;
  assign s2_valid  = s2_valid_q;

`ifdef PC_REDIRECT_PERF_EN
  logic [31:0] redirect_cnt_q, redirect_cnt_d;
  logic [31:0] kill_cnt_q, kill_cnt_d;

  // A redirect completes only on the edge where the PC actually loads the target.
  always_comb begin
    redirect_cnt_d = redirect_cnt_q;
    kill_cnt_d     = kill_cnt_q;
    if (reset) begin
      redirect_cnt_d = '0;
      kill_cnt_d     = '0;
    end else if (!icache_stall) begin
      if (pc_sel)   redirect_cnt_d = redirect_cnt_q + 32'd1;
      if (flush_s1) kill_cnt_d     = kill_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    redirect_cnt_q <= redirect_cnt_d;
    kill_cnt_q     <= kill_cnt_d;
  end

  assign redirect_cnt = redirect_cnt_q;
  assign kill_cnt     = kill_cnt_q;
`endif

endmodule
